mdu_issue_ctrl: RTL and testbench
=================================

MDU_ISSUE_CTRL -- requirements
Module: mdu_issue_ctrl

Interface
REQ-001 SHALL have parameter MULT_TIME, default 4'd5: busy cycles loaded on mult/multu issue.
REQ-002 SHALL have parameter DIV_TIME, default 4'd10: busy cycles loaded on div/divu issue.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-005 SHALL have port InstrValid_E, input, 1: E-stage slot holds a real instruction (not a bubble).
REQ-006 SHALL have port EnE, input, 1: E-stage pipeline register advances at the next edge.
REQ-007 SHALL have port MDClass_E, input, 4: E-stage class; 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none.
REQ-008 SHALL have port IsMD_D, input, 1: D-stage instruction is any of classes 1-8.
REQ-009 SHALL have port Busy, input, 1: busy flag returned by the MDU.
REQ-010 SHALL have port Start, output, 1: one-cycle issue request to the MDU.
REQ-011 SHALL have port MDUOP, output, 4: 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo, 0000 otherwise.
REQ-012 SHALL have port Time, output, 4: latency for the MDU; MULT_TIME, DIV_TIME, or 0.
REQ-013 SHALL have port ReadHILO, output, 2: 01 mflo, 10 mfhi, 00 otherwise.
REQ-014 SHALL have port Stall_D, output, 1: freeze F/D, bubble into E.
REQ-015 SHALL have port Err, output, 1: sticky protocol-violation flag.

Function
REQ-016 SHALL decode MDUOP, Time, ReadHILO combinationally from MDClass_E when InstrValid_E=1, else drive all zero.
REQ-017 SHALL hold a 2-bit FSM: IDLE, RUN, DRAIN.
REQ-018 SHALL hold a 4-bit down-counter cnt and an issued flag.
REQ-019 SHALL assert Start = InstrValid_E & class in 1-4 & !issued & state==IDLE; combinational, same cycle as the instruction in E.
REQ-020 SHALL, on a Start cycle, load cnt <= Time and go to RUN.
REQ-021 SHALL decrement cnt by 1 per cycle in RUN; RUN->IDLE when cnt==1 and Busy==0 next; RUN->DRAIN when cnt==1 and Busy==1 at that edge.
REQ-022 SHALL stay in DRAIN while Busy=1; DRAIN->IDLE on the first edge with Busy=0; cnt stays 0 in DRAIN.
REQ-023 SHALL set issued on a Start cycle when EnE=0; clear issued on any edge with EnE=1; a held E-stage mul/div SHALL issue exactly once.
REQ-024 SHALL assert Stall_D = IsMD_D & (Start | state!=IDLE | Busy), combinationally.
REQ-025 SHALL drop any class 1-4 request when state!=IDLE and InstrValid_E=1 and issued=0 (no Start), and set Err.
REQ-026 SHALL set Err when Busy=1 in IDLE with Start=0 and issued=0; Err clears only on reset.
REQ-027 SHALL never assert Start for classes 5-8; mthi/mtlo/mfhi/mflo produce only MDUOP/ReadHILO decode.
REQ-028 SHALL ignore operand values; divide-by-zero is issued normally with DIV_TIME.

Reset
REQ-029 SHALL, on reset=1 at a posedge, set state=IDLE, cnt=0, issued=0, Err=0; reset has priority over Start.
REQ-030 SHALL, in a reset cycle and the cycle after, produce Start=0 unless the E-stage inputs request issue; Stall_D follows REQ-024 from IDLE.
REQ-031 SHALL abandon an in-flight RUN/DRAIN on reset mid-operation with no further Start.

Verification
REQ-032 SHALL cover: mult in E, EnE=1 -> Start=1 one cycle, MDUOP=0001, Time=5; RUN for 5 cycles; mflo in D stalled through the Start cycle and 5 following cycles.
REQ-033 SHALL cover: divu in E with EnE=0 for 3 cycles -> Start high on the first cycle only, MDUOP=0100, Time=10, Err=0.
REQ-034 SHALL cover: mfhi in E, MDU idle -> ReadHILO=10, Start=0, Stall_D=0 for an unrelated D instruction.
REQ-035 SHALL cover: Busy held 2 cycles beyond cnt expiry -> DRAIN entered, Stall_D held with IsMD_D=1, IDLE on the first Busy=0 edge.
REQ-036 SHALL cover: reset asserted 3 cycles into div RUN -> state=IDLE, cnt=0, Err=0 next cycle; Busy=0 -> Stall_D=0.
REQ-037 SHALL cover: Busy=1 while IDLE with no issue -> Err=1 next cycle, remains 1 until reset.

Source files
------------

// File: rtl/mdu_issue_ctrl_if.sv
// mdu_issue_ctrl_if: E/D-stage request side and MDU handshake of the issue controller
interface mdu_issue_ctrl_if;
  logic       InstrValid_E, EnE, IsMD_D, Busy, Start, Stall_D, Err;
  logic [3:0] MDClass_E, MDUOP, Time;
  logic [1:0] ReadHILO;
  modport master(
    output InstrValid_E, EnE, MDClass_E, IsMD_D, Busy,
    input  Start, MDUOP, Time, ReadHILO, Stall_D, Err
  );
  modport slave(
    input  InstrValid_E, EnE, MDClass_E, IsMD_D, Busy,
    output Start, MDUOP, Time, ReadHILO, Stall_D, Err
  );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: issues mul/div ops to the MDU once, tracks its latency and stalls D-stage HI/LO users
module mdu_issue_ctrl #(
  parameter logic [3:0] MULT_TIME = 4'd5,
  parameter logic [3:0] DIV_TIME  = 4'd10
) (
  input logic           clk,
  input logic           reset,
  mdu_issue_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t     state;
  logic [3:0] cnt, cls;
  logic       issued, err, v, is_mul, is_div, md, start, violation;
  always_comb begin
    cls          = bus.MDClass_E;
    v            = bus.InstrValid_E;
    is_mul       = v && (cls == 4'd1 || cls == 4'd2);
    is_div       = v && (cls == 4'd3 || cls == 4'd4);
    md           = is_mul || is_div;
    start        = md && !issued && state == IDLE;
    violation    = (state != IDLE && md && !issued) || (state == IDLE && bus.Busy && !start && !issued);
    bus.Start    = start;
    bus.MDUOP    = (v && cls >= 4'd1 && cls <= 4'd6) ? cls : 4'd0;
    bus.Time     = is_mul ? MULT_TIME : is_div ? DIV_TIME : 4'd0;
    bus.ReadHILO = !v ? 2'b00 : cls == 4'd8 ? 2'b01 : cls == 4'd7 ? 2'b10 : 2'b00;
    bus.Stall_D  = bus.IsMD_D && (start || state != IDLE || bus.Busy);
    bus.Err      = err;
  end
  // a held E-stage op keeps issued set so it cannot start the MDU a second time
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      issued <= 1'b0;
      err    <= 1'b0;
    end else begin
      issued <= bus.EnE ? 1'b0 : (issued || start);
      if (violation) err <= 1'b1;
      if (start) begin
        cnt   <= bus.Time;
        state <= RUN;
      end else if (state == RUN) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) state <= bus.Busy ? DRAIN : IDLE;
      end else if (state == DRAIN && !bus.Busy) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// tb_mdu_issue_ctrl: directed scenarios plus random traffic checked against a cycle-stamp reference model
module tb_mdu_issue_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  mdu_issue_ctrl_if bus();
  mdu_issue_ctrl #(.MULT_TIME(4'd5), .DIV_TIME(4'd10)) dut (.clk(clk), .reset(reset), .bus(bus));
  int n_chk = 0, n_fail = 0;
  bit m_active, m_issued, m_err;
  int m_end, cyc = 0, starts, stalls;
  logic       o_start, o_stall, o_err;
  logic [1:0] o_rd;
  logic [3:0] o_op, o_time;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic int lat(input int c);
    return (c == 1 || c == 2) ? 5 : (c == 3 || c == 4) ? 10 : 0;
  endfunction
  // model: the controller is busy until the window of Time cycles after issue ends, then while Busy holds
  task automatic step(input bit rst, input bit v, input bit ene, input logic [3:0] c, input bit ismd, input bit busy);
    bit md, e_start, e_stall;
    int e_op, e_time, e_rd;
    reset = rst;
    bus.InstrValid_E = v;
    bus.EnE = ene;
    bus.MDClass_E = c;
    bus.IsMD_D = ismd;
    bus.Busy = busy;
    @(negedge clk);
    md      = v && c >= 1 && c <= 4;
    e_start = md && !m_issued && !m_active;
    e_op    = (v && c >= 1 && c <= 6) ? int'(c) : 0;
    e_time  = v ? lat(int'(c)) : 0;
    e_rd    = !v ? 0 : c == 8 ? 1 : c == 7 ? 2 : 0;
    e_stall = ismd && (e_start || m_active || busy);
    o_start = bus.Start;
    o_stall = bus.Stall_D;
    o_err   = bus.Err;
    o_rd    = bus.ReadHILO;
    o_op    = bus.MDUOP;
    o_time  = bus.Time;
    check("start", 8'(o_start), 8'(e_start));
    check("mduop", 8'(o_op), 8'(e_op));
    check("time", 8'(o_time), 8'(e_time));
    check("readhilo", 8'(o_rd), 8'(e_rd));
    check("stall_d", 8'(o_stall), 8'(e_stall));
    check("err", 8'(o_err), 8'(m_err));
    starts += int'(o_start);
    stalls += int'(o_stall);
    if (rst) begin
      m_active = 0;
      m_issued = 0;
      m_err    = 0;
    end else begin
      if ((m_active && md && !m_issued) || (!m_active && busy && !e_start && !m_issued)) m_err = 1;
      if (e_start) begin
        m_active = 1;
        m_end    = cyc + e_time;
      end else if (m_active && cyc >= m_end) m_active = busy;
      m_issued = ene ? 0 : (m_issued || e_start);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1;
    bus.InstrValid_E = 0; bus.EnE = 1; bus.MDClass_E = 0; bus.IsMD_D = 0; bus.Busy = 0;
    repeat (2) @(posedge clk);
    #1;
    step(1, 0, 1, 4'd0, 1, 0);
    step(1, 1, 1, 4'd1, 1, 0);
    step(0, 0, 1, 4'd0, 0, 0);
    // mult issue, mflo waiting in D
    starts = 0; stalls = 0;
    step(0, 1, 1, 4'd1, 1, 0);
    check("mult_start", 8'(o_start), 8'd1);
    check("mult_op", 8'(o_op), 8'd1);
    check("mult_time", 8'(o_time), 8'd5);
    repeat (4) step(0, 0, 1, 4'd0, 1, 1);
    step(0, 0, 1, 4'd0, 1, 0);
    step(0, 0, 1, 4'd0, 1, 0);
    check("mult_stall_cycles", 8'(stalls), 8'd6);
    check("mult_starts", 8'(starts), 8'd1);
    // divu held in E for three cycles
    starts = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 4'd4, 0, 0);
      if (i == 0) begin
        check("divu_op", 8'(o_op), 8'd4);
        check("divu_time", 8'(o_time), 8'd10);
      end
    end
    step(0, 1, 1, 4'd4, 0, 0);
    repeat (7) step(0, 0, 1, 4'd0, 0, 0);
    check("divu_starts", 8'(starts), 8'd1);
    check("divu_err", 8'(o_err), 8'd0);
    // mfhi with idle MDU
    step(0, 1, 1, 4'd7, 0, 0);
    check("mfhi_rd", 8'(o_rd), 8'd2);
    check("mfhi_start", 8'(o_start), 8'd0);
    check("mfhi_stall", 8'(o_stall), 8'd0);
    step(0, 1, 1, 4'd8, 1, 0);
    // Busy outlasting the latency window
    stalls = 0;
    step(0, 1, 1, 4'd2, 1, 0);
    repeat (5) step(0, 0, 1, 4'd0, 1, 1);
    repeat (2) step(0, 0, 1, 4'd0, 1, 1);
    step(0, 0, 1, 4'd0, 1, 0);
    check("drain_stall_cycles", 8'(stalls), 8'd9);
    step(0, 0, 1, 4'd0, 1, 0);
    check("drain_idle_stall", 8'(o_stall), 8'd0);
    // reset in the middle of a div
    step(0, 1, 1, 4'd3, 0, 0);
    repeat (3) step(0, 0, 1, 4'd0, 0, 1);
    step(1, 0, 1, 4'd0, 1, 1);
    step(0, 0, 1, 4'd0, 1, 0);
    check("rst_mid_stall", 8'(o_stall), 8'd0);
    check("rst_mid_err", 8'(o_err), 8'd0);
    // Busy while idle is a sticky error
    step(0, 0, 1, 4'd0, 0, 1);
    step(0, 0, 1, 4'd0, 0, 0);
    check("idle_busy_err", 8'(o_err), 8'd1);
    repeat (3) step(0, 0, 1, 4'd0, 0, 0);
    check("err_sticky", 8'(o_err), 8'd1);
    step(1, 0, 1, 4'd0, 0, 0);
    step(0, 0, 1, 4'd0, 0, 0);
    check("err_cleared", 8'(o_err), 8'd0);
    for (int i = 0; i < 800; i++) begin
      bit rst, v, ene, ismd, busy;
      logic [3:0] c;
      rst  = $urandom_range(0, 29) == 0;
      v    = $urandom_range(0, 3) != 0;
      ene  = $urandom_range(0, 2) != 0;
      ismd = $urandom_range(0, 1) == 1;
      c    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      busy = m_active ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
      step(rst, v, ene, c, ismd, busy);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
